// File: rtl/led_pattern_sequencer.sv
// Steps the LED decoder through its 20 {cfg, idx} positions, either on a
// programmable timer (RUN) or on single-step pulses (STOP).
module led_pattern_sequencer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       dir,
    output logic [3:0] bcd,
    output logic       mode,
    output logic       select,
    output logic       running,
    output logic       adv,
    output logic       wrap
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [1:0]       cfg, cfg_nxt;
    logic             adv_nxt;
    logic             wrap_nxt;

    function automatic logic [3:0] bcd_of(input logic [2:0] i);
        case (i)
            3'd0:    bcd_of = 4'd0;
            3'd1:    bcd_of = 4'd1;
            3'd2:    bcd_of = 4'd2;
            3'd3:    bcd_of = 4'd4;
            default: bcd_of = 4'd8;
        endcase
    endfunction

    // Leaving RUN takes priority over a terminal count in the same cycle,
    // and a run request in STOP swallows any coincident step.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        adv_nxt   = 1'b0;
        case (state)
            STOP: begin
                if (run) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (step) begin
                    adv_nxt = 1'b1;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nxt = STOP;
                    cnt_nxt   = '0;
                end else if (cnt == TERM) begin
                    cnt_nxt = '0;
                    adv_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STOP;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        idx_nxt  = idx;
        cfg_nxt  = cfg;
        wrap_nxt = 1'b0;
        if (adv_nxt) begin
            if (!dir) begin
                if (idx < 3'd4) begin
                    idx_nxt = idx + 3'd1;
                end else begin
                    idx_nxt  = 3'd0;
                    cfg_nxt  = cfg + 2'd1;
                    wrap_nxt = (cfg == 2'd3);
                end
            end else begin
                if (idx > 3'd0) begin
                    idx_nxt = idx - 3'd1;
                end else begin
                    idx_nxt  = 3'd4;
                    cfg_nxt  = cfg - 2'd1;
                    wrap_nxt = (cfg == 2'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= STOP;
            cnt     <= '0;
            idx     <= 3'd0;
            cfg     <= 2'd0;
            bcd     <= 4'd0;
            running <= 1'b0;
            adv     <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            cfg     <= cfg_nxt;
            bcd     <= bcd_of(idx_nxt);
            running <= (state_nxt == RUN);
            adv     <= adv_nxt;
            wrap    <= wrap_nxt;
        end
    end

    assign mode   = cfg[1];
    assign select = cfg[0];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV = 4.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, step, dir;
    logic [3:0] bcd;
    logic       mode, select, running, adv, wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] bcd_tab [5] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};

    led_pattern_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
        .bcd(bcd), .mode(mode), .select(select),
        .running(running), .adv(adv), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bcd !== 4'd0) begin n_fail++; $display("FAIL reset_bcd got %0d want 0", bcd); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        // walk to (cfg2, idx3): 13 forward steps
        for (int i = 0; i < 13; i++) begin
            step = 1'b1; tick(); step = 1'b0;
        end
        n_checks++; if ({bcd, mode, select} !== {4'd4, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL pre_reset_pos got %0d/%b%b want 4/10", bcd, mode, select); end
        run = 1'b1; tick(); tick();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL pre_reset_running got %b want 1", running); end
        rst = 1'b1; tick();
        n_checks++; if ({bcd, mode, select, running, adv, wrap} !== 9'd0)
            begin n_fail++; $display("FAIL midrun_reset got bcd=%0d m=%b s=%b r=%b a=%b w=%b want all 0",
                                     bcd, mode, select, running, adv, wrap); end
        tick();
        rst = 1'b0; run = 1'b0;
        tick();
        n_checks++; if ({bcd, mode, select, running, adv, wrap} !== 9'd0)
            begin n_fail++; $display("FAIL post_reset_idle got bcd=%0d r=%b a=%b want 0", bcd, running, adv); end
    endtask

    task automatic test_forward_step();
        int adv_cnt = 0;
        do_reset();
        dir = 1'b0;
        for (int i = 0; i < 20; i++) begin
            int k = (i + 1) % 20;
            step = 1'b1; tick(); step = 1'b0;
            if (adv === 1'b1) adv_cnt++;
            n_checks++; if (bcd !== bcd_tab[k % 5])
                begin n_fail++; $display("FAIL fwd_bcd[%0d] got %0d want %0d", i, bcd, bcd_tab[k % 5]); end
            n_checks++; if ({mode, select} !== 2'(k / 5))
                begin n_fail++; $display("FAIL fwd_cfg[%0d] got %b%b want %0d", i, mode, select, k / 5); end
            n_checks++; if (wrap !== (i == 19))
                begin n_fail++; $display("FAIL fwd_wrap[%0d] got %b want %b", i, wrap, (i == 19)); end
            tick();
            n_checks++; if (adv !== 1'b0 || wrap !== 1'b0)
                begin n_fail++; $display("FAIL fwd_pulse_width[%0d] got adv=%b wrap=%b want 0", i, adv, wrap); end
        end
        n_checks++; if (adv_cnt != 20) begin n_fail++; $display("FAIL fwd_adv_count got %0d want 20", adv_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dir = 1'b0;
        step = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (adv !== 1'b1 || bcd !== bcd_tab[i])
                begin n_fail++; $display("FAIL b2b[%0d] got adv=%b bcd=%0d want 1/%0d", i, adv, bcd, bcd_tab[i]); end
        end
        step = 1'b0;
        dir = 1'b1; tick(); dir = 1'b0; tick();
        n_checks++; if (bcd !== 4'd4 || adv !== 1'b0)
            begin n_fail++; $display("FAIL dir_hold got bcd=%0d adv=%b want 4/0", bcd, adv); end
    endtask

    task automatic test_reverse_wrap();
        do_reset();
        dir = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_checks++; if ({bcd, mode, select, wrap, adv} !== {4'd8, 1'b1, 1'b1, 1'b1, 1'b1})
            begin n_fail++; $display("FAIL rev_first got bcd=%0d m=%b s=%b w=%b a=%b want 8/1/1/1/1",
                                     bcd, mode, select, wrap, adv); end
        tick();
        step = 1'b1; tick(); step = 1'b0;
        n_checks++; if ({bcd, mode, select, wrap, adv} !== {4'd4, 1'b1, 1'b1, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL rev_second got bcd=%0d m=%b s=%b w=%b a=%b want 4/1/1/0/1",
                                     bcd, mode, select, wrap, adv); end
        dir = 1'b0;
    endtask

    task automatic test_timed_run();
        int nadv = 0;
        do_reset();
        run = 1'b1; tick();
        n_checks++; if (running !== 1'b1 || adv !== 1'b0)
            begin n_fail++; $display("FAIL run_start got running=%b adv=%b want 1/0", running, adv); end
        for (int e = 2; e <= 13; e++) begin
            step = (e == 3 || e == 7 || e == 8);
            tick();
            n_checks++; if (adv !== (e % 4 == 1))
                begin n_fail++; $display("FAIL run_adv[edge %0d] got %b want %b", e, adv, (e % 4 == 1)); end
            if (e % 4 == 1) begin
                nadv++;
                n_checks++; if (bcd !== bcd_tab[nadv])
                    begin n_fail++; $display("FAIL run_bcd[%0d] got %0d want %0d", nadv, bcd, bcd_tab[nadv]); end
            end
        end
        step = 1'b0;
        run = 1'b0; tick();
    endtask

    task automatic test_stop_terminal();
        do_reset();
        run = 1'b1; tick();
        tick(); tick(); tick();
        // counter now at terminal count
        run = 1'b0; tick();
        n_checks++; if (adv !== 1'b0 || running !== 1'b0 || bcd !== 4'd0)
            begin n_fail++; $display("FAIL stop_tc got adv=%b running=%b bcd=%0d want 0/0/0", adv, running, bcd); end
        tick(); tick();
        n_checks++; if (bcd !== 4'd0 || adv !== 1'b0)
            begin n_fail++; $display("FAIL stop_hold got bcd=%0d adv=%b want 0/0", bcd, adv); end
        run = 1'b1; tick();
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++; if (adv !== (e == 4))
                begin n_fail++; $display("FAIL restart_adv[%0d] got %b want %b", e, adv, (e == 4)); end
        end
        n_checks++; if (bcd !== 4'd1) begin n_fail++; $display("FAIL restart_bcd got %0d want 1", bcd); end
        run = 1'b0; tick();
    endtask

    task automatic test_collision();
        do_reset();
        run = 1'b1; step = 1'b1; tick(); step = 1'b0;
        n_checks++; if (running !== 1'b1 || adv !== 1'b0 || bcd !== 4'd0)
            begin n_fail++; $display("FAIL collide got running=%b adv=%b bcd=%0d want 1/0/0", running, adv, bcd); end
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++; if (adv !== (e == 4))
                begin n_fail++; $display("FAIL collide_adv[%0d] got %b want %b", e, adv, (e == 4)); end
        end
        n_checks++; if (bcd !== 4'd1) begin n_fail++; $display("FAIL collide_bcd got %0d want 1", bcd); end
        run = 1'b0; tick();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; dir = 1'b0;
        test_reset();
        test_forward_step();
        test_back_to_back();
        test_reverse_wrap();
        test_timed_run();
        test_stop_terminal();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
